// File: rtl/hash_pipeline_prog.sv
// Programmable H3 hash pipeline: NUM_HASH hashes per address, each the XOR of
// the seed rows selected by the address 1-bits, over a 2-stage valid/ready pipe.
module hash_pipeline_prog #(
  parameter int          W         = 4096,
  parameter int          NUM_HASH  = 4,
  parameter int          HASH_SIZE = $clog2(W),
  parameter int          ADDR_SIZE = 22,
  parameter int          GROUP     = 8,
  parameter logic [15:0] SEED_MULT = 16'h9E37,
  parameter int          HIDX_W    = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1,
  parameter int          BIDX_W    = $clog2(ADDR_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] in_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] out_addr,
  output logic [HASH_SIZE-1:0] hash_value [0:NUM_HASH-1],
  input  logic                 cfg_we,
  input  logic [HIDX_W-1:0]    cfg_hash_idx,
  input  logic [BIDX_W-1:0]    cfg_bit_idx,
  input  logic [HASH_SIZE-1:0] cfg_wdata,
  output logic [HASH_SIZE-1:0] cfg_rdata
);

  localparam int NGROUP = (ADDR_SIZE + GROUP - 1) / GROUP;
  localparam int APAD_W = NGROUP * GROUP;

  function automatic logic [HASH_SIZE-1:0] seed_default(input int i, input int j);
    logic [31:0] p;
    p = 32'(j + 1) * 32'(2 * i + 1) * 32'(SEED_MULT);
    return p[HASH_SIZE-1:0];
  endfunction

  logic [HASH_SIZE-1:0] seed_q    [NUM_HASH][ADDR_SIZE];
  logic [HASH_SIZE-1:0] seed_pad  [NUM_HASH][APAD_W];
  logic [APAD_W-1:0]    addr_pad;

  logic                 s1_valid_q;
  logic [ADDR_SIZE-1:0] s1_addr_q;
  logic [HASH_SIZE-1:0] s1_part_q [NUM_HASH][NGROUP];
  logic [HASH_SIZE-1:0] s1_part_d [NUM_HASH][NGROUP];

  logic                 out_valid_q;
  logic [ADDR_SIZE-1:0] out_addr_q;
  logic [HASH_SIZE-1:0] hash_q    [NUM_HASH];
  logic [HASH_SIZE-1:0] hash_d    [NUM_HASH];
  logic [HASH_SIZE-1:0] cfg_rdata_q;

  logic s2_en, s1_en, accept, idx_ok, wr_ok;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && !cfg_we;
  assign accept   = in_valid && in_ready;

  assign idx_ok = (int'(cfg_hash_idx) < NUM_HASH) && (int'(cfg_bit_idx) < ADDR_SIZE);
  assign wr_ok  = cfg_we && idx_ok;

  // Pad the last address group with zero bits and zero seeds so every
  // group is uniformly GROUP wide.
  assign addr_pad = APAD_W'(in_addr);
  for (genvar h = 0; h < NUM_HASH; h++) begin : g_pad_h
    for (genvar j = 0; j < APAD_W; j++) begin : g_pad_j
      if (j < ADDR_SIZE) begin : g_real
        assign seed_pad[h][j] = seed_q[h][j];
      end else begin : g_zero
        assign seed_pad[h][j] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HASH; i++)
        for (int j = 0; j < ADDR_SIZE; j++)
          seed_q[i][j] <= seed_default(i, j);
    end else if (wr_ok) begin
      seed_q[cfg_hash_idx][cfg_bit_idx] <= cfg_wdata;
    end
  end

  // Read samples the pre-write contents, so a same-cycle write shows next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_rdata_q <= '0;
    else if (idx_ok) cfg_rdata_q <= seed_q[cfg_hash_idx][cfg_bit_idx];
    else cfg_rdata_q <= '0;
  end

  always_comb begin
    for (int h = 0; h < NUM_HASH; h++)
      for (int g = 0; g < NGROUP; g++)
        s1_part_d[h][g] = '0;
    for (int h = 0; h < NUM_HASH; h++)
      for (int g = 0; g < NGROUP; g++)
        for (int k = 0; k < GROUP; k++)
          if (addr_pad[g*GROUP + k])
            s1_part_d[h][g] = s1_part_d[h][g] ^ seed_pad[h][g*GROUP + k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      for (int h = 0; h < NUM_HASH; h++)
        for (int g = 0; g < NGROUP; g++)
          s1_part_q[h][g] <= '0;
    end else if (s1_en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= in_addr;
        s1_part_q <= s1_part_d;
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NUM_HASH; h++) begin
      hash_d[h] = '0;
      for (int g = 0; g < NGROUP; g++)
        hash_d[h] = hash_d[h] ^ s1_part_q[h][g];
    end
  end

  // Output registers only load on a real transfer, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      for (int h = 0; h < NUM_HASH; h++)
        hash_q[h] <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_addr_q <= s1_addr_q;
        hash_q     <= hash_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign cfg_rdata = cfg_rdata_q;
  always_comb begin
    for (int h = 0; h < NUM_HASH; h++)
      hash_value[h] = hash_q[h];
  end

endmodule

// File: tb/tb_hash_pipeline_prog.sv
// Scoreboard bench for hash_pipeline_prog: random and directed traffic checked
// against an XOR-of-selected-seeds reference model.
module tb_hash_pipeline_prog;
  localparam int NH = 4;
  localparam int HS = 12;
  localparam int AS = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, cfg_we;
  logic [AS-1:0] in_addr, out_addr;
  logic [HS-1:0] hash_value [0:NH-1];
  logic [1:0]    cfg_hash_idx;
  logic [4:0]    cfg_bit_idx;
  logic [HS-1:0] cfg_wdata, cfg_rdata;

  hash_pipeline_prog dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .hash_value(hash_value),
    .cfg_we(cfg_we), .cfg_hash_idx(cfg_hash_idx), .cfg_bit_idx(cfg_bit_idx),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AS-1:0]        addr;
    logic [NH-1:0][HS-1:0] h;
  } exp_t;

  exp_t          sb[$];
  logic [HS-1:0] seed_m [NH][AS];
  int            total = 0;
  int            bad = 0;
  logic          rand_ready = 1'b0;

  function automatic logic [HS-1:0] dflt(int i, int j);
    return HS'(((j + 1) * (2 * i + 1) * 'h9E37) % 4096);
  endfunction

  function automatic void reseed();
    for (int i = 0; i < NH; i++)
      for (int j = 0; j < AS; j++)
        seed_m[i][j] = dflt(i, j);
  endfunction

  function automatic exp_t model(logic [AS-1:0] a);
    exp_t e;
    e.addr = a;
    for (int h = 0; h < NH; h++) begin
      e.h[h] = '0;
      for (int j = 0; j < AS; j++)
        if (a[j]) e.h[h] = e.h[h] ^ seed_m[h][j];
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Accept logger: model result captured with the seeds in force at accept time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(in_addr));
      if (cfg_we && cfg_hash_idx < NH && cfg_bit_idx < AS)
        seed_m[cfg_hash_idx][cfg_bit_idx] = cfg_wdata;
    end
  end

  // Output monitor: pops on every transfer, checks hold during stalls.
  logic          stall_prev = 1'b0;
  logic [AS-1:0] st_addr;
  logic [HS-1:0] st_h [NH];
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("stall_addr", 32'(out_addr), 32'(st_addr));
        for (int h = 0; h < NH; h++) check("stall_hash", 32'(hash_value[h]), 32'(st_h[h]));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h expected=none", out_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_addr", 32'(out_addr), 32'(e.addr));
          for (int h = 0; h < NH; h++) check("out_hash", 32'(hash_value[h]), 32'(e.h[h]));
        end
      end
      stall_prev = out_valid && !out_ready;
      st_addr = out_addr;
      for (int h = 0; h < NH; h++) st_h[h] = hash_value[h];
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [AS-1:0] a, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_addr = a;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(tries), 0);
  endtask

  task automatic cfg_write(input logic [1:0] i, input logic [4:0] j, input logic [HS-1:0] d);
    cfg_we = 1'b1;
    cfg_hash_idx = i;
    cfg_bit_idx = j;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  task automatic fill_stalled(output int n_acc);
    logic acc;
    n_acc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_addr = AS'($urandom);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        in_addr = AS'($urandom);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    sb.delete();
    reseed();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic single_addr1();
    int t;
    out_ready = 1'b1;
    send(22'd1, t);
    check("lat_t1_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_t2_valid", 32'(out_valid), 1);
    check("addr1_out_addr", 32'(out_addr), 1);
    check("addr1_hash0", 32'(hash_value[0]), 32'h E37);
    check("addr1_hash1", 32'(hash_value[1]), 32'h AA5);
    drain();
  endtask

  initial begin
    int t, n;
    in_valid = 1'b0; in_addr = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_hash_idx = '0; cfg_bit_idx = '0; cfg_wdata = '0;
    rst_n = 1'b1;
    #2;
    do_reset();

    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_addr", 32'(out_addr), 0);
    for (int h = 0; h < NH; h++) check("rst_hash", 32'(hash_value[h]), 0);
    check("rst_cfg_rdata", 32'(cfg_rdata), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    single_addr1();

    send(22'd3, t);
    @(posedge clk);
    #1;
    check("addr3_hash0", 32'(hash_value[0]), 32'h259);
    send(22'd0, t);
    @(posedge clk);
    #1;
    for (int h = 0; h < NH; h++) check("addr0_hash", 32'(hash_value[h]), 0);
    drain();

    // Config write blocks the input for that cycle; next item sees the new seed.
    in_valid = 1'b1;
    in_addr = 22'd8;
    cfg_we = 1'b1; cfg_hash_idx = 2'd2; cfg_bit_idx = 5'd3; cfg_wdata = 12'h123;
    @(negedge clk);
    check("cfg_we_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("rdata_old", 32'(cfg_rdata), 32'(dflt(2, 3)));
    @(negedge clk);
    check("post_cfg_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rdata_new", 32'(cfg_rdata), 32'h123);
    @(posedge clk);
    #1;
    check("addr8_hash2", 32'(hash_value[2]), 32'h123);
    drain();
    cfg_write(2'd2, 5'd22, 12'hFFF);
    check("rdata_oor", 32'(cfg_rdata), 0);
    cfg_bit_idx = 5'd3;
    @(posedge clk);
    #1;
    check("rdata_after_oor", 32'(cfg_rdata), 32'h123);
    send(22'h3FFFFF, t);
    drain();

    // Random backpressure stream with occasional seed rewrites.
    rand_ready = 1'b1;
    for (int a = 1; a <= 100; a++) begin
      send(AS'(a), t);
      if (a % 17 == 0)
        cfg_write(2'($urandom_range(0, 3)), 5'($urandom_range(0, 21)), HS'($urandom));
    end
    for (int k = 0; k < 50; k++) send(AS'($urandom), t);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Full throughput: with out_ready high every item is taken on its first try.
    send(AS'($urandom), t);
    for (int k = 0; k < 20; k++) begin
      send(AS'($urandom), t);
      check("throughput_tries", 32'(t), 1);
    end
    drain();

    fill_stalled(n);
    check("stall_accepts", 32'(n), 2);
    check("stall_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    drain();

    fill_stalled(n);
    check("stall2_accepts", 32'(n), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_addr", 32'(out_addr), 0);
    sb.delete();
    reseed();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_rdata", 32'(cfg_rdata), 0);
    single_addr1();
    send(22'd8, t);
    @(posedge clk);
    #1;
    check("addr8_default_hash2", 32'(hash_value[2]), 32'(dflt(2, 3)));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
